// File: rtl/uart_tx_scheduler_pkg.sv
// Shared IO definitions for the UART transmit scheduler: FSM encoding, byte width
// and the index-width helper used by the arbiter and its selector.
package uart_tx_scheduler_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Width of an index into an n-entry vector; never zero so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
// Returns the one-hot grant, its index, and whether any request was set.
module rr_pick
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output is given a default before the search so no path infers a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX channel among NUM_REQ byte streams,
// with optional packet locking, a burst cap and a one-byte registered holding stage.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_PACKETS = 1,
    parameter int MAX_BURST    = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] Req_data,
    input  logic [NUM_REQ-1:0]        Req_last,
    output logic [NUM_REQ-1:0]        Req_ready,
    output logic [BYTE_W-1:0]         DataIn,
    output logic                      DataInValid,
    input  logic                      DataInReady,
    output logic [NUM_REQ-1:0]        Grant,
    output logic                      Busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    gidx_q,  gidx_d;
    logic [IDX_W-1:0]    ptr_q,   ptr_d;
    logic [7:0]          burst_q, burst_d;
    logic [BYTE_W-1:0]   data_q,  data_d;
    logic                valid_q, valid_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;

    logic                hold_free, accept, release_g;
    logic                sel_valid, sel_last;
    logic [BYTE_W-1:0]   sel_byte;
    logic [8:0]          burst_inc;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (Req_valid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == gidx_q) begin
                sel_valid = Req_valid[i];
                sel_last  = Req_last[i];
                sel_byte  = Req_data[i*BYTE_W +: BYTE_W];
            end
        end

        // The hold may refill in the same cycle it drains.
        hold_free = !valid_q || DataInReady;
        accept    = (state_q == XFER) && sel_valid && hold_free;
        burst_inc = {1'b0, burst_q} + 9'd1;
        release_g = accept && ((LOCK_PACKETS == 0) || sel_last ||
                               (burst_inc == 9'(MAX_BURST)));
        Req_ready = (state_q == XFER) ? (grant_q & {NUM_REQ{hold_free}}) : '0;

        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = XFER;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    burst_d = '0;
                end
            end
            XFER: begin
                if (accept) burst_d = burst_inc[7:0];
                if (release_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d  = sel_byte;
            valid_d = 1'b1;
        end else if (DataInReady) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DataIn      = data_q;
    assign DataInValid = valid_q;
    assign Grant       = grant_q;
    assign Busy        = (|grant_q) || valid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: per-cycle vector table plus stream sequences
// for burst capping and the unlocked (per-byte) arbitration variant.
module tb_uart_tx_scheduler;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        rdy;
        logic [1:0]  e_grant;
        logic [1:0]  e_ready;
        logic        e_dv;
        logic [7:0]  e_data;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic        dready;
    logic        sel;

    logic [1:0]  a_ready, a_grant, b_ready, b_grant;
    logic [7:0]  a_data, b_data;
    logic        a_dv, a_busy, b_dv, b_busy;
    logic [1:0]  act_ready, act_grant;
    logic [7:0]  act_data;
    logic        act_dv, act_busy;

    int n_checks = 0;
    int n_errors = 0;

    vec_t       vecs[$];
    item_t      src0[$], src1[$];
    logic [8:0] acc_log[$], exp_acc[$];
    logic [7:0] out_log[$], exp_out[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(2), .LOCK_PACKETS(1), .MAX_BURST(4)) dut_a (
        .Clock(clk), .Reset(rst), .Req_valid(req_valid), .Req_data(req_data),
        .Req_last(req_last), .Req_ready(a_ready), .DataIn(a_data), .DataInValid(a_dv),
        .DataInReady(dready), .Grant(a_grant), .Busy(a_busy)
    );

    uart_tx_scheduler #(.NUM_REQ(2), .LOCK_PACKETS(0), .MAX_BURST(16)) dut_b (
        .Clock(clk), .Reset(rst), .Req_valid(req_valid), .Req_data(req_data),
        .Req_last(req_last), .Req_ready(b_ready), .DataIn(b_data), .DataInValid(b_dv),
        .DataInReady(dready), .Grant(b_grant), .Busy(b_busy)
    );

    assign act_ready = sel ? b_ready : a_ready;
    assign act_grant = sel ? b_grant : a_grant;
    assign act_data  = sel ? b_data  : a_data;
    assign act_dv    = sel ? b_dv    : a_dv;
    assign act_busy  = sel ? b_busy  : a_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [1:0] v, input logic [15:0] d,
                                input logic [1:0] l, input logic rd, input logic [1:0] g,
                                input logic [1:0] rq, input logic dv, input logic [7:0] dd,
                                input logic b);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.rdy = rd;
        x.e_grant = g; x.e_ready = rq; x.e_dv = dv; x.e_data = dd; x.e_busy = b;
        vecs.push_back(x);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; dready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives queued bytes honouring Req_ready; logs accepted bytes and bytes leaving the hold.
    task automatic run_streams(input int start0, input int start1, input int budget);
        int cyc  = 0;
        int tail = 0;
        acc_log.delete();
        out_log.delete();
        while ((src0.size() != 0 || src1.size() != 0 || tail < 3) && cyc < budget) begin
            @(negedge clk);
            req_valid = '0; req_last = '0; req_data = '0; dready = 1'b1;
            if (src0.size() != 0 && cyc >= start0) begin
                req_valid[0] = 1'b1; req_data[7:0] = src0[0].d; req_last[0] = src0[0].l;
            end
            if (src1.size() != 0 && cyc >= start1) begin
                req_valid[1] = 1'b1; req_data[15:8] = src1[0].d; req_last[1] = src1[0].l;
            end
            #1;
            if (req_valid[0] && act_ready[0]) begin
                acc_log.push_back({1'b0, src0[0].d});
                void'(src0.pop_front());
            end
            if (req_valid[1] && act_ready[1]) begin
                acc_log.push_back({1'b1, src1[0].d});
                void'(src1.pop_front());
            end
            if (act_dv && dready) out_log.push_back(act_data);
            if (src0.size() == 0 && src1.size() == 0) tail++;
            cyc++;
        end
        check("stream_done_in_budget", 32'(src0.size() + src1.size()), 32'd0);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_acc_count"}, 32'(acc_log.size()), 32'(exp_acc.size()));
        check({tag, "_out_count"}, 32'(out_log.size()), 32'(exp_out.size()));
        for (int i = 0; i < exp_acc.size() && i < acc_log.size(); i++)
            check($sformatf("%s_acc%0d", tag, i), 32'(acc_log[i]), 32'(exp_acc[i]));
        for (int i = 0; i < exp_out.size() && i < out_log.size(); i++)
            check($sformatf("%s_out%0d", tag, i), 32'(out_log[i]), 32'(exp_out[i]));
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; dready = 1'b1;

        // Single requester: 0x41,0x42,0x43(last).
        add(0, 2'b01, 16'h0041, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0);
        add(0, 2'b01, 16'h0041, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 1);
        add(0, 2'b01, 16'h0042, 2'b00, 1, 2'b01, 2'b01, 1, 8'h41, 1);
        add(0, 2'b01, 16'h0043, 2'b01, 1, 2'b01, 2'b01, 1, 8'h42, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 1, 8'h43, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 0, 8'h43, 0);
        add(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 0, 8'h43, 0);
        // Contention: both requesters send 1-byte packets; 8 packets alternate 0,1,0,1...
        for (int k = 0; k < 16; k++) begin
            if (k == 0)
                add(0, 2'b11, 16'hB1A0, 2'b11, 1, 2'b00, 2'b00, 0, 8'h00, 0);
            else if (k % 2 == 1)
                add(0, 2'b11, 16'hB1A0, 2'b11, 1, (k % 4 == 1) ? 2'b01 : 2'b10,
                    (k % 4 == 1) ? 2'b01 : 2'b10, 0,
                    (k == 1) ? 8'h00 : ((k % 4 == 3) ? 8'hA0 : 8'hB1), 1);
            else
                add(0, 2'b11, 16'hB1A0, 2'b11, 1, 2'b00, 2'b00, 1,
                    (k % 4 == 2) ? 8'hA0 : 8'hB1, 1);
        end
        add(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 1, 8'hB1, 1);
        // Backpressure: 0x55 held through five stalled cycles, then bypass accept.
        add(0, 2'b01, 16'h0055, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0);
        add(0, 2'b01, 16'h0055, 2'b00, 0, 2'b01, 2'b01, 0, 8'h00, 1);
        for (int k = 0; k < 5; k++)
            add(0, 2'b01, 16'h0056, 2'b00, 0, 2'b01, 2'b00, 1, 8'h55, 1);
        add(0, 2'b01, 16'h0056, 2'b00, 1, 2'b01, 2'b01, 1, 8'h55, 1);
        add(0, 2'b01, 16'h0057, 2'b01, 1, 2'b01, 2'b01, 1, 8'h56, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 1, 8'h57, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 2'b00, 0, 8'h57, 0);
        // Mid-packet reset with the pointer at 1 and a full hold.
        add(0, 2'b01, 16'h0060, 2'b00, 0, 2'b00, 2'b00, 0, 8'h57, 0);
        add(0, 2'b01, 16'h0060, 2'b00, 0, 2'b01, 2'b01, 0, 8'h57, 1);
        add(1, 2'b01, 16'h0061, 2'b00, 0, 2'b01, 2'b00, 1, 8'h60, 1);
        add(0, 2'b11, 16'hB261, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00, 0);
        add(0, 2'b11, 16'hB261, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b01, 2'b01, 1, 8'h61, 1);
        add(0, 2'b00, 16'h0000, 2'b00, 1, 2'b01, 2'b01, 0, 8'h61, 1);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req_valid = vecs[i].valid; req_data = vecs[i].data;
            req_last = vecs[i].last; dready = vecs[i].rdy;
            #1;
            check($sformatf("row%0d_grant", i), 32'(act_grant), 32'(vecs[i].e_grant));
            check($sformatf("row%0d_ready", i), 32'(act_ready), 32'(vecs[i].e_ready));
            check($sformatf("row%0d_dv",    i), 32'(act_dv),    32'(vecs[i].e_dv));
            check($sformatf("row%0d_data",  i), 32'(act_data),  32'(vecs[i].e_data));
            check($sformatf("row%0d_busy",  i), 32'(act_busy),  32'(vecs[i].e_busy));
        end

        // Burst cap of 4: req1 streams 10 unterminated bytes while req0 waits with one packet.
        do_reset();
        src0.delete(); src1.delete(); exp_acc.delete(); exp_out.delete();
        src0.push_back('{8'hA0, 1'b1});
        for (int i = 0; i < 10; i++) src1.push_back('{8'(8'h10 + i), 1'b0});
        for (int i = 0; i < 4; i++) exp_acc.push_back({1'b1, 8'(8'h10 + i)});
        exp_acc.push_back({1'b0, 8'hA0});
        for (int i = 4; i < 10; i++) exp_acc.push_back({1'b1, 8'(8'h10 + i)});
        foreach (exp_acc[i]) exp_out.push_back(exp_acc[i][7:0]);
        run_streams(1, 0, 60);
        compare_logs("burst");

        // Unlocked variant: 3-byte packets from both requesters interleave byte by byte.
        sel = 1'b1;
        do_reset();
        src0.delete(); src1.delete(); exp_acc.delete(); exp_out.delete();
        for (int i = 0; i < 3; i++) begin
            src0.push_back('{8'(8'h20 + i), i == 2});
            src1.push_back('{8'(8'h30 + i), i == 2});
            exp_acc.push_back({1'b0, 8'(8'h20 + i)});
            exp_acc.push_back({1'b1, 8'(8'h30 + i)});
        end
        foreach (exp_acc[i]) exp_out.push_back(exp_acc[i][7:0]);
        run_streams(0, 0, 60);
        compare_logs("nolock");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
